// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator side of the ALU operand/result interface. Commands are queued in a
// small FIFO and issued one at a time to the ALU. After ALU_LAT cycles the
// result and status are captured and returned on a valid/ready response port.
// Optional feature macro: ALU_SEQ_STICKY_STATUS_EN (sticky OR of returned status).
module alu_cmd_sequencer #(
    parameter int OP_W       = 3,
    parameter int ARG_W      = 4,
    parameter int RES_W      = 8,
    parameter int ALU_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [OP_W-1:0]  i_cmd_op,
    input  logic [ARG_W-1:0] i_cmd_a,
    input  logic [ARG_W-1:0] i_cmd_b,
    output logic [OP_W-1:0]  o_alu_op,
    output logic [ARG_W-1:0] o_alu_arg_A,
    output logic [ARG_W-1:0] o_alu_arg_B,
    input  logic [RES_W-1:0] i_alu_result,
    input  logic [3:0]       i_alu_status,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [RES_W-1:0] o_rsp_result,
    output logic [3:0]       o_rsp_status,
    output logic             o_busy,
    input  logic             i_sticky_clr,
    output logic [3:0]       o_sticky_status
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CMD_W = OP_W + 2 * ARG_W;
    localparam logic [3:0]       LAT_LOAD = 4'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Command FIFO storage and bookkeeping
    logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Operand, latency and response registers
    logic [OP_W-1:0]  r_alu_op;
    logic [ARG_W-1:0] r_alu_a;
    logic [ARG_W-1:0] r_alu_b;
    logic [3:0]       r_lat_cnt;
    logic             r_rsp_valid;
    logic [RES_W-1:0] r_rsp_result;
    logic [3:0]       r_rsp_status;

    // FSM control strobes
    logic w_push;
    logic w_pop;
    logic w_load_lat;
    logic w_capture;
    logic w_fifo_empty;
    logic w_rsp_hs;

    // Ready comes from the registered count only, so a full FIFO never
    // accepts even if the same cycle would pop.
    assign o_cmd_ready  = (r_count != FULL_CNT);
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = i_cmd_valid & o_cmd_ready;
    assign w_rsp_hs     = r_rsp_valid & i_rsp_ready;

    // FIFO storage write; no reset so it can map onto RAM resources
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_op, i_cmd_a, i_cmd_b};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth wraps naturally
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_fifo_empty) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (r_lat_cnt == 4'd0) w_state_next = S_RESP;
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_next = w_fifo_empty ? S_IDLE : S_ISSUE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM output strobes; a pop in IDLE or on response accept feeds the next ISSUE
    always_comb begin
        w_pop      = 1'b0;
        w_load_lat = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE:  w_pop      = !w_fifo_empty;
            S_ISSUE: w_load_lat = 1'b1;
            S_WAIT:  w_capture  = (r_lat_cnt == 4'd0);
            S_RESP:  w_pop      = i_rsp_ready & !w_fifo_empty;
            default: w_pop      = 1'b0;
        endcase
    end

    // Operand registers drive the ALU and hold until the next pop
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else if (w_pop) begin
            {r_alu_op, r_alu_a, r_alu_b} <= r_mem[r_rd_ptr];
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lat_cnt <= '0;
        end else if (w_load_lat) begin
            r_lat_cnt <= LAT_LOAD;
        end else if ((r_state == S_WAIT) && (r_lat_cnt != 4'd0)) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
        end
    end

    // Response capture and hold until the consumer accepts
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_status <= '0;
        end else if (w_capture) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= i_alu_result;
            r_rsp_status <= i_alu_status;
        end else if (w_rsp_hs) begin
            r_rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_SEQ_STICKY_STATUS_EN
    logic [3:0] r_sticky;

    // Sticky status accumulates every accepted response; clear has priority
    always_ff @(posedge i_clk) begin
        if (i_reset || i_sticky_clr) begin
            r_sticky <= '0;
        end else if (w_rsp_hs) begin
            r_sticky <= r_sticky | r_rsp_status;
        end
    end

    assign o_sticky_status = r_sticky;
`else
    // Sticky feature not built: clear input intentionally has no effect
    logic w_unused_sticky_clr;
    assign w_unused_sticky_clr = i_sticky_clr;
    assign o_sticky_status     = 4'b0000;
`endif

    assign o_alu_op     = r_alu_op;
    assign o_alu_arg_A  = r_alu_a;
    assign o_alu_arg_B  = r_alu_b;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_status = r_rsp_status;
    assign o_busy       = (r_state != S_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: table vectors, hand sequences and randomized
// traffic against a queue-based reference model. Two instances: ALU_LAT=1 and 3.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance with ALU_LAT=1
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] alu_op;
    logic [3:0] alu_a, alu_b;
    logic [7:0] alu_res;
    logic [3:0] alu_st;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_res;
    logic [3:0] rsp_st;
    logic       busy, sticky_clr;
    logic [3:0] sticky;

    // Instance with ALU_LAT=3
    logic       cmd_valid3, cmd_ready3;
    logic [2:0] cmd_op3;
    logic [3:0] cmd_a3, cmd_b3;
    logic [2:0] alu_op3;
    logic [3:0] alu_a3, alu_b3;
    logic [7:0] alu_res3;
    logic [3:0] alu_st3;
    logic       rsp_valid3, rsp_ready3;
    logic [7:0] rsp_res3;
    logic [3:0] rsp_st3;
    logic       busy3, sticky_clr3;
    logic [3:0] sticky3;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural ALU: returns {status, result}
    function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        logic [3:0] s;
        case (op)
            3'd0:    r = {4'b0, a} - {4'b0, b} - 8'd1;
            3'd1:    r = {a, b};
            3'd2:    r = {4'b0, a} + {4'b0, b};
            3'd3:    r = {4'b0, a} * {4'b0, b};
            3'd4:    r = {4'b0, a ^ b};
            3'd5:    r = ~{a, b};
            3'd6:    r = {4'b0, a & b};
            default: r = {4'b0, a | b};
        endcase
        s[0] = (op == 3'd0) && ({1'b0, a} < ({1'b0, b} + 5'd1));
        s[1] = (r == 8'd0);
        s[2] = op[1];
        s[3] = op[2];
        return {s, r};
    endfunction

    assign {alu_st, alu_res}   = alu_fn(alu_op, alu_a, alu_b);
    assign {alu_st3, alu_res3} = alu_fn(alu_op3, alu_a3, alu_b3);

    alu_cmd_sequencer #(.OP_W(3), .ARG_W(4), .RES_W(8), .ALU_LAT(1), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
        .o_alu_op(alu_op), .o_alu_arg_A(alu_a), .o_alu_arg_B(alu_b),
        .i_alu_result(alu_res), .i_alu_status(alu_st),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_res), .o_rsp_status(rsp_st),
        .o_busy(busy), .i_sticky_clr(sticky_clr), .o_sticky_status(sticky)
    );

    alu_cmd_sequencer #(.OP_W(3), .ARG_W(4), .RES_W(8), .ALU_LAT(3), .FIFO_DEPTH(4)) dut3 (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_valid(cmd_valid3), .o_cmd_ready(cmd_ready3),
        .i_cmd_op(cmd_op3), .i_cmd_a(cmd_a3), .i_cmd_b(cmd_b3),
        .o_alu_op(alu_op3), .o_alu_arg_A(alu_a3), .o_alu_arg_B(alu_b3),
        .i_alu_result(alu_res3), .i_alu_status(alu_st3),
        .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3),
        .o_rsp_result(rsp_res3), .o_rsp_status(rsp_st3),
        .o_busy(busy3), .i_sticky_clr(sticky_clr3), .o_sticky_status(sticky3)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic [3:0] st;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single command into an idle ALU_LAT=1 block: latency, operands, result
    task automatic run_single(input vec_t v);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
        step();
        cmd_valid = 1'b0;
        check("single_valid_t1", {31'd0, rsp_valid}, 32'd0);
        step();
        check("single_alu_issue", {21'd0, alu_op, alu_a, alu_b}, {21'd0, v.op, v.a, v.b});
        step();
        check("single_valid_t3", {31'd0, rsp_valid}, 32'd0);
        step();
        check("single_valid_t4", {31'd0, rsp_valid}, 32'd1);
        check("single_result", {24'd0, rsp_res}, {24'd0, v.res});
        check("single_status", {28'd0, rsp_st}, {28'd0, v.st});
        $display("txn op=%0d a=%0h b=%0h -> res=%0h st=%b", v.op, v.a, v.b, rsp_res, rsp_st);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("single_after_accept", {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    logic [2:0]  fop [6];
    logic [3:0]  fa  [6];
    logic [3:0]  fb  [6];
    logic [11:0] exp_q [$];
    logic [11:0] e;
    logic [3:0]  exp_sticky;
    int          wait_cnt;
    int          valid_seen;
    int          n_rsp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd0, 4'h5, 4'h1, 8'h03, 4'b0000};
        vecs[1] = '{3'd1, 4'hA, 4'h5, 8'hA5, 4'b0000};
        vecs[2] = '{3'd2, 4'hF, 4'hF, 8'h1E, 4'b0100};
        vecs[3] = '{3'd3, 4'hF, 4'hF, 8'hE1, 4'b0100};
        vecs[4] = '{3'd4, 4'h7, 4'h7, 8'h00, 4'b1010};
        vecs[5] = '{3'd0, 4'h1, 4'h0, 8'h00, 4'b0010};
        vecs[6] = '{3'd0, 4'h2, 4'h3, 8'hFE, 4'b0001};
        vecs[7] = '{3'd7, 4'h0, 4'h0, 8'h00, 4'b1110};

        rst = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0; sticky_clr = 0;
        cmd_valid3 = 0; cmd_op3 = 0; cmd_a3 = 0; cmd_b3 = 0; rsp_ready3 = 0; sticky_clr3 = 0;
        step();
        step();
        check("reset_outs", {3'd0, rsp_valid, busy, alu_op, alu_a, alu_b, rsp_res, rsp_st, sticky}, 32'd0);
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_outs3", {3'd0, rsp_valid3, busy3, alu_op3, alu_a3, alu_b3, rsp_res3, rsp_st3, sticky3}, 32'd0);
        rst = 1'b0;
        step();

        // Table-driven single commands
        for (int i = 0; i < 8; i++) run_single(vecs[i]);

        // Sticky: 0001 then 0010 accumulate to 0011, clear returns 0000
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        check("sticky_cleared", {28'd0, sticky}, 32'd0);
        run_single(vecs[6]);
        run_single(vecs[5]);
`ifdef ALU_SEQ_STICKY_STATUS_EN
        check("sticky_accum", {28'd0, sticky}, 32'h3);
`else
        check("sticky_accum", {28'd0, sticky}, 32'h0);
`endif
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        check("sticky_clr_pulse", {28'd0, sticky}, 32'd0);

        // Fill with responses blocked. The head is moved into the operand
        // registers right away, so the 4-deep FIFO refuses only after 5 accepts.
        fop[0] = 3'd1; fa[0] = 4'hA; fb[0] = 4'h5;
        fop[1] = 3'd2; fa[1] = 4'h3; fb[1] = 4'h4;
        fop[2] = 3'd3; fa[2] = 4'h5; fb[2] = 4'h6;
        fop[3] = 3'd4; fa[3] = 4'h9; fb[3] = 4'h3;
        fop[4] = 3'd0; fa[4] = 4'h8; fb[4] = 4'h2;
        fop[5] = 3'd6; fa[5] = 4'hC; fb[5] = 4'hA;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("fill_ready", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b1; cmd_op = fop[i]; cmd_a = fa[i]; cmd_b = fb[i];
            step();
        end
        cmd_op = fop[5]; cmd_a = fa[5]; cmd_b = fb[5];
        check("full_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        cmd_valid = 1'b0;
        // Held response: stable A5, ALU operands not re-issued
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_result", {24'd0, rsp_res}, 32'hA5);
            check("hold_alu", {21'd0, alu_op, alu_a, alu_b}, {21'd0, fop[0], fa[0], fb[0]});
            step();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_cnt = 0;
            while (!rsp_valid && wait_cnt < 20) begin
                step();
                wait_cnt++;
            end
            e = alu_fn(fop[i], fa[i], fb[i]);
            check("drain_valid", {31'd0, rsp_valid}, 32'd1);
            check("drain_order", {20'd0, rsp_st, rsp_res}, {20'd0, e});
            if (i > 0) check("throughput_gap", wait_cnt, 32'd2);
            $display("txn drain #%0d res=%0h st=%b", i, rsp_res, rsp_st);
            step();
        end
        rsp_ready = 1'b0;
        step();
        check("drain_idle", {30'd0, busy, cmd_ready}, 32'd1);

        // ALU_LAT=3: sample exactly three cycles after ISSUE
        cmd_valid3 = 1'b1; cmd_op3 = 3'd0; cmd_a3 = 4'h2; cmd_b3 = 4'h3;
        step();
        cmd_valid3 = 1'b0;
        step();
        check("lat3_alu_issue", {21'd0, alu_op3, alu_a3, alu_b3}, {21'd0, 3'd0, 4'h2, 4'h3});
        step(); step(); step();
        check("lat3_valid_t5", {31'd0, rsp_valid3}, 32'd0);
        step();
        check("lat3_valid_t6", {31'd0, rsp_valid3}, 32'd1);
        check("lat3_result", {24'd0, rsp_res3}, 32'hFE);
        check("lat3_status", {28'd0, rsp_st3}, 32'h1);
        $display("txn lat3 res=%0h st=%b", rsp_res3, rsp_st3);
        rsp_ready3 = 1'b1; step(); rsp_ready3 = 1'b0;

        // Reset during WAIT with three commands queued
        for (int i = 0; i < 4; i++) begin
            cmd_valid3 = 1'b1; cmd_op3 = fop[i]; cmd_a3 = fa[i]; cmd_b3 = fb[i];
            step();
        end
        cmd_valid3 = 1'b0;
        check("midrst_busy_before", {31'd0, busy3}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_after", {29'd0, rsp_valid3, busy3, cmd_ready3}, 32'd1);
        rsp_ready3 = 1'b1;
        valid_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid3 || busy3) valid_seen++;
            step();
        end
        rsp_ready3 = 1'b0;
        check("midrst_no_stale", valid_seen, 32'd0);

        // Randomized traffic against queue reference model
        exp_sticky = 4'd0;
        n_rsp = 0;
        for (int c = 0; c < 800; c++) begin
            logic       hs;
            logic [3:0] hs_st;
            hs = 1'b0;
            hs_st = 4'd0;
            cmd_valid  = ($urandom_range(0, 99) < 60);
            cmd_op     = 3'($urandom_range(0, 7));
            cmd_a      = 4'($urandom_range(0, 15));
            cmd_b      = 4'($urandom_range(0, 15));
            rsp_ready  = ($urandom_range(0, 99) < 50);
            sticky_clr = ($urandom_range(0, 31) == 0);
            if (cmd_valid && cmd_ready) exp_q.push_back(alu_fn(cmd_op, cmd_a, cmd_b));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_rsp", {20'd0, rsp_st, rsp_res}, {20'd0, e});
                    hs = 1'b1;
                    hs_st = e[11:8];
                    $display("txn rnd #%0d res=%0h st=%b", n_rsp, rsp_res, rsp_st);
                    n_rsp++;
                end
            end
            step();
`ifdef ALU_SEQ_STICKY_STATUS_EN
            if (sticky_clr) exp_sticky = 4'd0;
            else if (hs) exp_sticky = exp_sticky | hs_st;
`else
            exp_sticky = 4'd0;
`endif
            check("rnd_sticky", {28'd0, sticky}, {28'd0, exp_sticky});
        end
        cmd_valid = 1'b0; sticky_clr = 1'b0; rsp_ready = 1'b1;
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            if (rsp_valid) begin
                e = exp_q.pop_front();
                check("rnd_drain_rsp", {20'd0, rsp_st, rsp_res}, {20'd0, e});
            end
            step();
            wait_cnt++;
        end
        check("rnd_queue_empty", exp_q.size(), 32'd0);
        check("rnd_final_idle", {30'd0, busy, rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
